// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and helpers for the truth-table input sequencer.
package tt_seq_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_e;

    localparam int DWELL_CNT_W = 32;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_btn_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, stability counter and
// a one-cycle event on each debounced rising edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The event is registered together with the level change so the
    // consumer acts one cycle after the debounced level moves.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/truth_table_sequencer.sv
// Steps the N_VARS-bit demo input vector through all combinations with a
// programmable dwell; buttons give run/pause, step and clear.
// Define TT_AUTO_STOP_EN to stop in PAUSE after every wrap (single sweep).
//
// state    | meaning
// ST_RUN   | dwell counter runs, vec advances on each dwell expiry
// ST_PAUSE | dwell counter held, vec moves only by step or clear
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int unsigned N_VARS      = 2,
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned DWELL_MS    = 2000,
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_run,
    input  logic              btn_step,
    input  logic              btn_clear,
    output logic [N_VARS-1:0] vec,
    output logic              vec_valid,
    output logic              running,
    output logic              wrap
);

    localparam int unsigned DWELL_CYCLES    = ms_to_cycles(CLK_HZ, DWELL_MS);
    localparam int unsigned DEBOUNCE_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam logic [DWELL_CNT_W-1:0] DWELL_LAST = DWELL_CNT_W'(DWELL_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [N_VARS-1:0]       vec_q, vec_d;
    logic [DWELL_CNT_W-1:0]  dwell_q, dwell_d;
    logic                    vec_valid_q, vec_valid_d;
    logic                    wrap_q, wrap_d;

    logic run_ev, step_ev, clear_ev;
    logic expire, advance;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk       (clk),
        .rst       (rst),
        .btn_raw_i (btn_run),
        .rise_o    (run_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk       (clk),
        .rst       (rst),
        .btn_raw_i (btn_step),
        .rise_o    (step_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk       (clk),
        .rst       (rst),
        .btn_raw_i (btn_clear),
        .rise_o    (clear_ev)
    );

    assign expire  = (state_q == ST_RUN) && (dwell_q == DWELL_LAST);
    assign advance = expire || ((state_q == ST_PAUSE) && step_ev);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        dwell_d     = dwell_q;
        vec_valid_d = 1'b0;
        wrap_d      = 1'b0;

        if (state_q == ST_RUN) begin
            dwell_d = expire ? '0 : dwell_q + DWELL_CNT_W'(1);
        end

        // Clear beats any advance landing in the same cycle.
        if (clear_ev) begin
            vec_d       = '0;
            dwell_d     = '0;
            vec_valid_d = (vec_q != '0);
        end else if (advance) begin
            vec_d       = vec_q + N_VARS'(1);
            dwell_d     = '0;
            vec_valid_d = 1'b1;
            wrap_d      = &vec_q;
        end

        if (run_ev) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end

`ifdef TT_AUTO_STOP_EN
        if (wrap_d) begin
            state_d = ST_PAUSE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            vec_q       <= '0;
            dwell_q     <= '0;
            vec_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            dwell_q     <= dwell_d;
            vec_valid_q <= vec_valid_d;
            wrap_q      <= wrap_d;
        end
    end

    assign vec       = vec_q;
    assign vec_valid = vec_valid_q;
    assign wrap      = wrap_q;
    assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with DWELL=5 and DEBOUNCE=2 cycles.
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_step = 1'b0;
    logic       btn_clear = 1'b0;
    logic [1:0] vec;
    logic       vec_valid;
    logic       running;
    logic       wrap;
    logic [4:0] obs;

    int checks = 0;
    int failures = 0;

    truth_table_sequencer #(
        .N_VARS      (2),
        .CLK_HZ      (1000),
        .DWELL_MS    (5),
        .DEBOUNCE_MS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_step  (btn_step),
        .btn_clear (btn_clear),
        .vec       (vec),
        .vec_valid (vec_valid),
        .running   (running),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    // Observed bundle: {vec, vec_valid, wrap, running}
    assign obs = {vec, vec_valid, wrap, running};

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        rst = 1'b1;
        tick(2);
        exp = {2'd0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_values got=%b exp=%b", obs, exp);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        logic [4:0] exp;
        logic       run_exp;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            run_exp = 1'b1;
`ifdef TT_AUTO_STOP_EN
            if (i == 20) run_exp = 1'b0;
`endif
            exp = {2'((i / 5) % 4), (i % 5 == 0), (i == 20), run_exp};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL sweep cycle=%0d got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_run_pause();
        logic [4:0] exp;
        tick(2);
        btn_run = 1'b1;
        tick(4);
        btn_run = 1'b0;
        exp = {2'd1, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL pause_before got=%b exp=%b", obs, exp);
        end
        tick(1);
        exp = {2'd1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL pause_enter got=%b exp=%b", obs, exp);
        end
        for (int i = 0; i < 7; i++) begin
            tick(1);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL pause_frozen i=%0d got=%b exp=%b", i, obs, exp);
            end
        end
        btn_run = 1'b1;
        tick(4);
        btn_run = 1'b0;
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL resume_before got=%b exp=%b", obs, exp);
        end
        tick(1);
        exp = {2'd1, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL resume_enter got=%b exp=%b", obs, exp);
        end
        tick(2);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL resume_partial got=%b exp=%b", obs, exp);
        end
        tick(1);
        exp = {2'd2, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL resume_advance got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_step_in_run();
        logic [4:0] exp;
        logic [1:0] ev;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            ev = (i < 5) ? 2'd2 : ((i < 10) ? 2'd3 : 2'd0);
            exp = {ev, (i == 5 || i == 10), (i == 10), 1'b1};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL step_in_run cycle=%0d got=%b exp=%b", i, obs, exp);
            end
            if (i == 1) btn_step = 1'b1;
            if (i == 5) btn_step = 1'b0;
        end
    endtask

    task automatic test_step_in_pause();
        logic [4:0] exp;
        tick(11);
        btn_run = 1'b1;
        tick(4);
        btn_run = 1'b0;
        tick(1);
        exp = {2'd3, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL pause_at3 got=%b exp=%b", obs, exp);
        end
        btn_step = 1'b1;
        tick(4);
        btn_step = 1'b0;
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL step_before got=%b exp=%b", obs, exp);
        end
        tick(1);
        exp = {2'd0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL step_wrap got=%b exp=%b", obs, exp);
        end
        tick(1);
        exp = {2'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL step_wrap_after got=%b exp=%b", obs, exp);
        end
        tick(2);
        btn_step = 1'b1;
        tick(4);
        btn_step = 1'b0;
        tick(1);
        exp = {2'd1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL step_plain got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_clear();
        logic [4:0] exp;
        tick(3);
        btn_step = 1'b1;
        tick(4);
        btn_step = 1'b0;
        tick(1);
        exp = {2'd2, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL step_to2 got=%b exp=%b", obs, exp);
        end
        tick(2);
        btn_clear = 1'b1;
        tick(1);
        btn_clear = 1'b0;
        exp = {2'd2, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL clear_glitch i=%0d got=%b exp=%b", i, obs, exp);
            end
        end
        btn_clear = 1'b1;
        tick(3);
        btn_clear = 1'b0;
        tick(1);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL clear_before got=%b exp=%b", obs, exp);
        end
        tick(1);
        exp = {2'd0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL clear_nonzero got=%b exp=%b", obs, exp);
        end
        tick(5);
        btn_clear = 1'b1;
        tick(3);
        btn_clear = 1'b0;
        exp = {2'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL clear_zero i=%0d got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_clear_at_expiry();
        logic [4:0] exp;
        btn_run = 1'b1;
        tick(4);
        btn_run = 1'b0;
        tick(1);
        exp = {2'd0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL rerun got=%b exp=%b", obs, exp);
        end
        tick(15);
        exp = {2'd3, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL run_to3 got=%b exp=%b", obs, exp);
        end
        btn_clear = 1'b1;
        tick(4);
        btn_clear = 1'b0;
        exp = {2'd3, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL clrexp_before got=%b exp=%b", obs, exp);
        end
        tick(1);
        exp = {2'd0, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL clrexp_hit got=%b exp=%b", obs, exp);
        end
        exp = {2'd0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL clrexp_hold i=%0d got=%b exp=%b", i, obs, exp);
            end
        end
        tick(1);
        exp = {2'd1, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL clrexp_next got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_reset_mid_dwell();
        logic [4:0] exp;
        tick(5);
        btn_run = 1'b1;
        tick(2);
        rst = 1'b1;
        #1;
        exp = {2'd0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", obs, exp);
        end
        btn_run = 1'b0;
        tick(2);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            exp = {2'(i / 5), (i % 5 == 0), 1'b0, 1'b1};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL post_reset cycle=%0d got=%b exp=%b", i, obs, exp);
            end
        end
    endtask

`ifdef TT_AUTO_STOP_EN
    task automatic test_auto_stop();
        logic [4:0] exp;
        exp = {2'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL auto_stop_hold i=%0d got=%b exp=%b", i, obs, exp);
            end
        end
        btn_run = 1'b1;
        tick(4);
        btn_run = 1'b0;
        tick(1);
        exp = {2'd0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL auto_stop_restart got=%b exp=%b", obs, exp);
        end
        tick(5);
        exp = {2'd1, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL auto_stop_advance got=%b exp=%b", obs, exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
`ifdef TT_AUTO_STOP_EN
        test_auto_stop();
`else
        test_run_pause();
        test_step_in_run();
        test_step_in_pause();
        test_clear();
        test_clear_at_expiry();
        test_reset_mid_dwell();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
